// File: rtl/udp_rx.sv
// udp_rx: receive-side UDP stage.
// Parses the 8-byte UDP header on beat 0 of the IP payload stream and filters
// on protocol, destination port, fragmentation and length. It strips the header
// and forwards the payload with per-packet metadata. Rejected packets are
// dropped whole.
// Optional macro UDP_STAT_CNT_EN: builds the saturating accepted/dropped packet
// counters. When it is undefined, both counter ports are tied to zero.
module udp_rx #(
    parameter logic [15:0] P_LOCAL_PORT = 16'd8080
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_dynamic_port,
    input  logic        i_dynamic_port_valid,
    input  logic [63:0] s_axis_ip_data,
    input  logic [55:0] s_axis_ip_user,
    input  logic [7:0]  s_axis_ip_keep,
    input  logic        s_axis_ip_last,
    input  logic        s_axis_ip_valid,
    output logic [63:0] m_axis_app_data,
    output logic [47:0] m_axis_app_user,
    output logic [7:0]  m_axis_app_keep,
    output logic        m_axis_app_last,
    output logic        m_axis_app_valid,
    output logic [15:0] o_rx_pkt_cnt,
    output logic [15:0] o_rx_drop_cnt
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t      state, state_nx;
    logic        user_load;
    logic [15:0] port_filter;

    // Header fields, meaningful only on beat 0 (IDLE)
    logic [15:0] src_port, dst_port, udp_len, ip_len;
    logic [7:0]  proto;
    logic        mf;
    logic [12:0] frag_off;
    logic        accept;

    assign src_port = s_axis_ip_data[63:48];
    assign dst_port = s_axis_ip_data[47:32];
    assign udp_len  = s_axis_ip_data[31:16];
    assign ip_len   = s_axis_ip_user[55:40];
    assign mf       = s_axis_ip_user[37];
    assign proto    = s_axis_ip_user[36:29];
    assign frag_off = s_axis_ip_user[28:16];

    // The checksum, the IP id and the reserved/DF flag bits play no part in filtering
    logic unused_fields;
    assign unused_fields = ^{s_axis_ip_user[39:38], s_axis_ip_user[15:0]};

    assign accept = (proto == 8'd17) && (dst_port == port_filter) &&
                    !mf && (frag_off == 13'd0) &&
                    (udp_len >= 16'd8) && (udp_len == ip_len);

    // Port filter register; a load only affects the next header compare
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            port_filter <= P_LOCAL_PORT;
        else if (i_dynamic_port_valid)
            port_filter <= i_dynamic_port;
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FSM next-state and header-latch decode
    always_comb begin
        state_nx  = state;
        user_load = 1'b0;
        case (state)
            IDLE: begin
                if (s_axis_ip_valid && !s_axis_ip_last) begin
                    if (accept) begin
                        state_nx  = FWD;
                        user_load = 1'b1;
                    end else begin
                        state_nx = DROP;
                    end
                end
            end
            FWD:     if (s_axis_ip_valid && s_axis_ip_last) state_nx = IDLE;
            DROP:    if (s_axis_ip_valid && s_axis_ip_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output register: payload beats pass through with one cycle of latency
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_axis_app_data  <= '0;
            m_axis_app_keep  <= '0;
            m_axis_app_last  <= 1'b0;
            m_axis_app_valid <= 1'b0;
        end else if (state == FWD && s_axis_ip_valid) begin
            m_axis_app_data  <= s_axis_ip_data;
            m_axis_app_keep  <= s_axis_ip_keep;
            m_axis_app_last  <= s_axis_ip_last;
            m_axis_app_valid <= 1'b1;
        end else begin
            m_axis_app_last  <= 1'b0;
            m_axis_app_valid <= 1'b0;
        end
    end

    // Per-packet metadata, captured from an accepted header and held for the packet
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            m_axis_app_user <= '0;
        else if (user_load)
            m_axis_app_user <= {udp_len - 16'd8, src_port, dst_port};
    end

`ifdef UDP_STAT_CNT_EN
    logic        pkt_inc, drop_inc;
    logic [15:0] pkt_cnt, drop_cnt;

    // Packet end events. A single-beat packet is resolved in IDLE.
    always_comb begin
        pkt_inc  = 1'b0;
        drop_inc = 1'b0;
        if (s_axis_ip_valid && s_axis_ip_last) begin
            case (state)
                IDLE:    if (accept) pkt_inc = 1'b1; else drop_inc = 1'b1;
                FWD:     pkt_inc  = 1'b1;
                DROP:    drop_inc = 1'b1;
                default: ;
            endcase
        end
    end

    // Saturating statistics counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (pkt_inc && pkt_cnt != 16'hFFFF)
                pkt_cnt <= pkt_cnt + 16'd1;
            if (drop_inc && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign o_rx_pkt_cnt  = pkt_cnt;
    assign o_rx_drop_cnt = drop_cnt;
`else
    assign o_rx_pkt_cnt  = '0;
    assign o_rx_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_udp_rx.sv
// Directed self-checking bench for udp_rx.
// Inputs are driven 1 ns after a rising edge. Outputs are checked 1 ns after the
// edge that captured the beat.
module tb_udp_rx;

`ifdef UDP_STAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] dyn_port = '0;
    logic        dyn_port_valid = 1'b0;
    logic [63:0] s_data = '0;
    logic [55:0] s_user = '0;
    logic [7:0]  s_keep = '0;
    logic        s_last = 1'b0;
    logic        s_valid = 1'b0;
    logic [63:0] m_data;
    logic [47:0] m_user;
    logic [7:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic [15:0] pkt_cnt, drop_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [15:0] exp_pkt = '0;
    logic [15:0] exp_drop = '0;

    udp_rx #(.P_LOCAL_PORT(16'd8080)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_dynamic_port       (dyn_port),
        .i_dynamic_port_valid (dyn_port_valid),
        .s_axis_ip_data       (s_data),
        .s_axis_ip_user       (s_user),
        .s_axis_ip_keep       (s_keep),
        .s_axis_ip_last       (s_last),
        .s_axis_ip_valid      (s_valid),
        .m_axis_app_data      (m_data),
        .m_axis_app_user      (m_user),
        .m_axis_app_keep      (m_keep),
        .m_axis_app_last      (m_last),
        .m_axis_app_valid     (m_valid),
        .o_rx_pkt_cnt         (pkt_cnt),
        .o_rx_drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [55:0] mk_user(input logic [15:0] len, input logic [2:0] flags,
                                            input logic [7:0] proto, input logic [12:0] off);
        return {len, flags, proto, off, 16'hABCD};
    endfunction

    function automatic logic [63:0] mk_hdr(input logic [15:0] src, input logic [15:0] dst,
                                           input logic [15:0] len);
        return {src, dst, len, 16'hBEEF};
    endfunction

    // Present one beat for one clock, then return 1 ns after the capturing edge
    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                        input logic [55:0] u);
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_user  = u;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        s_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 64'd0) begin errors++; $display("FAIL reset_data: got %h want 0", m_data); end
        checks++; if (m_user !== 48'd0) begin errors++; $display("FAIL reset_user: got %h want 0", m_user); end
        checks++; if ({m_keep, m_last} !== 9'd0) begin errors++; $display("FAIL reset_keep_last: got %h want 0", {m_keep, m_last}); end
        checks++; if ({pkt_cnt, drop_cnt} !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0", {pkt_cnt, drop_cnt}); end
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic check_counts(input string name);
        logic [15:0] ep, ed;
        ep = CNT_EN ? exp_pkt : 16'd0;
        ed = CNT_EN ? exp_drop : 16'd0;
        checks++; if (pkt_cnt !== ep) begin errors++; $display("FAIL %s_pkt_cnt: got %0d want %0d", name, pkt_cnt, ep); end
        checks++; if (drop_cnt !== ed) begin errors++; $display("FAIL %s_drop_cnt: got %0d want %0d", name, drop_cnt, ed); end
    endtask

    // Three beats: the header plus two full payload beats
    task automatic test_accept();
        logic [55:0] u;
        u = mk_user(16'd24, 3'b000, 8'd17, 13'd0);
        beat(mk_hdr(16'hC350, 16'd8080, 16'd24), 8'hFF, 1'b0, u);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL acc_hdr_valid: got %b want 0", m_valid); end
        beat(64'h0011223344556677, 8'hFF, 1'b0, u);
        checks++; if ({m_valid, m_last} !== 2'b10) begin errors++; $display("FAIL acc_b1_vl: got %b want 10", {m_valid, m_last}); end
        checks++; if (m_data !== 64'h0011223344556677) begin errors++; $display("FAIL acc_b1_data: got %h want 0011223344556677", m_data); end
        checks++; if (m_user !== {16'd16, 16'hC350, 16'd8080}) begin errors++; $display("FAIL acc_user: got %h want %h", m_user, {16'd16, 16'hC350, 16'd8080}); end
        beat(64'h8899AABBCCDDEEFF, 8'hFF, 1'b1, u);
        exp_pkt++;
        checks++; if ({m_valid, m_last} !== 2'b11) begin errors++; $display("FAIL acc_b2_vl: got %b want 11", {m_valid, m_last}); end
        checks++; if (m_data !== 64'h8899AABBCCDDEEFF || m_keep !== 8'hFF) begin errors++; $display("FAIL acc_b2_data: got %h/%h want 8899AABBCCDDEEFF/ff", m_data, m_keep); end
        checks++; if (m_user !== {16'd16, 16'hC350, 16'd8080}) begin errors++; $display("FAIL acc_user_held: got %h", m_user); end
        idle_cycle();
        checks++; if ({m_valid, m_last} !== 2'b00) begin errors++; $display("FAIL acc_after_vl: got %b want 00", {m_valid, m_last}); end
        check_counts("acc");
    endtask

    task automatic test_wrong_port();
        logic [55:0] u;
        u = mk_user(16'd24, 3'b000, 8'd17, 13'd0);
        beat(mk_hdr(16'hC350, 16'd9000, 16'd24), 8'hFF, 1'b0, u);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL port_hdr_valid: got %b want 0", m_valid); end
        beat(64'h1, 8'hFF, 1'b0, u);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL port_b1_valid: got %b want 0", m_valid); end
        beat(64'h2, 8'hFF, 1'b1, u);
        exp_drop++;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL port_b2_valid: got %b want 0", m_valid); end
        idle_cycle();
        check_counts("port");
    endtask

    // udp_len 13: five payload bytes in a single partial beat
    task automatic test_partial();
        logic [55:0] u;
        u = mk_user(16'd13, 3'b000, 8'd17, 13'd0);
        beat(mk_hdr(16'd5000, 16'd8080, 16'd13), 8'hFF, 1'b0, u);
        beat(64'hA1A2A3A4A5000000, 8'b1111_1000, 1'b1, u);
        exp_pkt++;
        checks++; if ({m_valid, m_last} !== 2'b11) begin errors++; $display("FAIL part_vl: got %b want 11", {m_valid, m_last}); end
        checks++; if (m_keep !== 8'b1111_1000) begin errors++; $display("FAIL part_keep: got %b want 11111000", m_keep); end
        checks++; if (m_user[47:32] !== 16'd5) begin errors++; $display("FAIL part_plen: got %0d want 5", m_user[47:32]); end
        idle_cycle();
        check_counts("part");
    endtask

    // A TCP packet directly followed by a UDP packet, then two UDP packets back to back
    task automatic test_back_to_back();
        logic [55:0] ut, ua, ub;
        ut = mk_user(16'd16, 3'b000, 8'd6, 13'd0);
        ua = mk_user(16'd16, 3'b000, 8'd17, 13'd0);
        ub = mk_user(16'd24, 3'b000, 8'd17, 13'd0);
        beat(mk_hdr(16'd1, 16'd8080, 16'd16), 8'hFF, 1'b0, ut);
        beat(64'hDEAD, 8'hFF, 1'b1, ut);
        exp_drop++;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_tcp_valid: got %b want 0", m_valid); end
        beat(mk_hdr(16'd2, 16'd8080, 16'd16), 8'hFF, 1'b0, ua);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_a_hdr: got %b want 0", m_valid); end
        beat(64'hAAAA, 8'hFF, 1'b1, ua);
        exp_pkt++;
        checks++; if ({m_valid, m_last, m_data} !== {2'b11, 64'hAAAA}) begin errors++; $display("FAIL b2b_a_data: got %b/%h want 11/aaaa", {m_valid, m_last}, m_data); end
        beat(mk_hdr(16'd3, 16'd8080, 16'd24), 8'hFF, 1'b0, ub);
        checks++; if ({m_valid, m_last} !== 2'b00) begin errors++; $display("FAIL b2b_b_hdr: got %b want 00", {m_valid, m_last}); end
        beat(64'hBBBB, 8'hFF, 1'b0, ub);
        checks++; if ({m_valid, m_last, m_data} !== {2'b10, 64'hBBBB}) begin errors++; $display("FAIL b2b_b1: got %b/%h want 10/bbbb", {m_valid, m_last}, m_data); end
        checks++; if (m_user !== {16'd16, 16'd3, 16'd8080}) begin errors++; $display("FAIL b2b_b_user: got %h", m_user); end
        // A valid gap mid-packet produces nothing and keeps the metadata
        idle_cycle();
        checks++; if ({m_valid, m_user} !== {1'b0, 16'd16, 16'd3, 16'd8080}) begin errors++; $display("FAIL b2b_gap: got %b/%h", m_valid, m_user); end
        beat(64'hCCCC, 8'hFF, 1'b1, ub);
        exp_pkt++;
        checks++; if ({m_valid, m_last, m_data} !== {2'b11, 64'hCCCC}) begin errors++; $display("FAIL b2b_b2: got %b/%h want 11/cccc", {m_valid, m_last}, m_data); end
        idle_cycle();
        check_counts("b2b");
    endtask

    // Filter conditions, each a two-beat packet; DF alone must still pass
    task automatic test_filters();
        logic [2:0]  flg [6] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
        logic [12:0] off [6] = '{13'd0, 13'd5, 13'd0, 13'd0, 13'd0, 13'd0};
        logic [15:0] ul  [6] = '{16'd16, 16'd16, 16'd7, 16'd16, 16'd16, 16'd8};
        logic [15:0] il  [6] = '{16'd16, 16'd16, 16'd7, 16'd24, 16'd16, 16'd8};
        bit          acc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [55:0] u;
        for (int i = 0; i < 6; i++) begin
            u = mk_user(il[i], flg[i], 8'd17, off[i]);
            beat(mk_hdr(16'd77, 16'd8080, ul[i]), 8'hFF, 1'b0, u);
            beat(64'h5555, 8'hFF, 1'b1, u);
            if (acc[i]) exp_pkt++; else exp_drop++;
            checks++; if (m_valid !== acc[i]) begin errors++; $display("FAIL filt%0d_valid: got %b want %b", i, m_valid, acc[i]); end
        end
        // Header-only packets finish in IDLE and produce no output
        beat(mk_hdr(16'd9, 16'd8080, 16'd8), 8'hFF, 1'b1, mk_user(16'd8, 3'b000, 8'd17, 13'd0));
        exp_pkt++;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_acc_valid: got %b want 0", m_valid); end
        beat(mk_hdr(16'd9, 16'd8081, 16'd8), 8'hFF, 1'b1, mk_user(16'd8, 3'b000, 8'd17, 13'd0));
        exp_drop++;
        idle_cycle();
        check_counts("filt");
    endtask

    task automatic test_dynamic_port();
        logic [55:0] u;
        u = mk_user(16'd16, 3'b000, 8'd17, 13'd0);
        dyn_port = 16'd1234;
        dyn_port_valid = 1'b1;
        idle_cycle();
        dyn_port_valid = 1'b0;
        beat(mk_hdr(16'd10, 16'd1234, 16'd16), 8'hFF, 1'b0, u);
        beat(64'h1234, 8'hFF, 1'b1, u);
        exp_pkt++;
        checks++; if ({m_valid, m_user[15:0]} !== {1'b1, 16'd1234}) begin errors++; $display("FAIL dyn_accept: got %b/%0d want 1/1234", m_valid, m_user[15:0]); end
        beat(mk_hdr(16'd10, 16'd8080, 16'd16), 8'hFF, 1'b0, u);
        beat(64'h8080, 8'hFF, 1'b1, u);
        exp_drop++;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL dyn_old_port: got %b want 0", m_valid); end
        dyn_port = 16'd8080;
        dyn_port_valid = 1'b1;
        idle_cycle();
        dyn_port_valid = 1'b0;
        check_counts("dyn");
    endtask

    task automatic test_reset_mid();
        logic [55:0] u;
        u = mk_user(16'd32, 3'b000, 8'd17, 13'd0);
        beat(mk_hdr(16'd20, 16'd8080, 16'd32), 8'hFF, 1'b0, u);
        beat(64'h1111, 8'hFF, 1'b0, u);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b want 1", m_valid); end
        s_data  = 64'h2222;
        s_valid = 1'b1;
        rst_n   = 1'b0;
        #1;
        exp_pkt  = '0;
        exp_drop = '0;
        checks++; if ({m_valid, m_last, m_keep} !== 10'd0) begin errors++; $display("FAIL rmid_ctrl: got %h want 0", {m_valid, m_last, m_keep}); end
        checks++; if ({m_data, m_user} !== 112'd0) begin errors++; $display("FAIL rmid_data_user: got %h/%h want 0", m_data, m_user); end
        check_counts("rmid");
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycle();
        u = mk_user(16'd16, 3'b000, 8'd17, 13'd0);
        beat(mk_hdr(16'd21, 16'd8080, 16'd16), 8'hFF, 1'b0, u);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rpost_hdr: got %b want 0", m_valid); end
        beat(64'h3333, 8'hF0, 1'b1, u);
        exp_pkt++;
        checks++; if ({m_valid, m_last, m_keep, m_data} !== {2'b11, 8'hF0, 64'h3333}) begin errors++; $display("FAIL rpost_beat: got %b/%h/%h", {m_valid, m_last}, m_keep, m_data); end
        checks++; if (m_user !== {16'd8, 16'd21, 16'd8080}) begin errors++; $display("FAIL rpost_user: got %h", m_user); end
        idle_cycle();
        check_counts("rpost");
    endtask

    initial begin
        test_reset();
        test_accept();
        test_wrong_port();
        test_partial();
        test_back_to_back();
        test_filters();
        test_dynamic_port();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
